// File: rtl/hdmi_line_fetcher.sv
// hdmi_line_fetcher: framebuffer-to-line-buffer feeder for the pixel-doubled
// 160x120 RGB332 video stage. It displays line y from one bank while it
// fetches line y+1 into the other bank over a req/ack byte interface.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no fetch in progress, mem_req low
// FETCH | streaming one source line into bank[line[0]], one byte per ack
// DRAIN | a new line trigger arrived mid-request; the issued request is
//       | held until its ack, then discarded, then the pending line starts
module hdmi_line_fetcher #(
  parameter int H_RES   = 160,
  parameter int V_RES   = 120,
  parameter int Y_LAST  = 131,
  parameter int ADDR_W  = 16,
  parameter int FB_BASE = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  output logic [7:0]        pixelData,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  output logic              busy,
  output logic              overrun
);

  localparam int IDX_W = $clog2(H_RES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(H_RES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [9:0]        y_prev;
  logic [9:0]        line_q;
  logic [IDX_W-1:0]  idx_q;
  logic [9:0]        pend_line;
  logic              pend_ok;

  logic [7:0] bank0 [H_RES];
  logic [7:0] bank1 [H_RES];

  logic              trig;
  logic [9:0]        trig_tgt;
  logic              trig_ok;
  logic              acked;
  logic              wr_en;

  logic              start;
  logic [9:0]        start_line;
  logic              advance;
  logic              finish;

  logic              in_range;
  logic [IDX_W-1:0]  x_idx;
  logic [7:0]        bank_rd;

  // Byte address of the first pixel of source line t, truncated to ADDR_W.
  function automatic logic [ADDR_W-1:0] line_base(input logic [9:0] t);
    logic [31:0] prod;
    prod = 32'(t) * 32'(H_RES);
    return ADDR_W'(FB_BASE) + prod[ADDR_W-1:0];
  endfunction

  // Line trigger: any change of y requests the line after it (wrapping at Y_LAST).
  always_comb begin
    trig     = (y != y_prev);
    trig_tgt = (y == 10'(Y_LAST)) ? 10'd0 : y + 10'd1;
    trig_ok  = (trig_tgt < 10'(V_RES));
    acked    = mem_req && mem_ack;
    wr_en    = !reset && (state_q == S_FETCH) && acked;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic plus the datapath strobes that go with each transition.
  always_comb begin
    state_d    = state_q;
    start      = 1'b0;
    start_line = trig_tgt;
    advance    = 1'b0;
    finish     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (trig && trig_ok) begin
          start   = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (trig) begin
          // An ack in the same cycle completes the byte, so restart at once;
          // otherwise the outstanding request must finish first.
          if (acked) begin
            if (trig_ok) begin
              start   = 1'b1;
              state_d = S_FETCH;
            end else begin
              finish  = 1'b1;
              state_d = S_IDLE;
            end
          end else begin
            state_d = S_DRAIN;
          end
        end else if (acked) begin
          if (idx_q == LAST_IDX) begin
            finish  = 1'b1;
            state_d = S_IDLE;
          end else begin
            advance = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (acked) begin
          // A trigger coinciding with the ack supersedes the stored pending line.
          if (trig) begin
            start_line = trig_tgt;
            if (trig_ok) begin
              start   = 1'b1;
              state_d = S_FETCH;
            end else begin
              finish  = 1'b1;
              state_d = S_IDLE;
            end
          end else begin
            start_line = pend_line;
            if (pend_ok) begin
              start   = 1'b1;
              state_d = S_FETCH;
            end else begin
              finish  = 1'b1;
              state_d = S_IDLE;
            end
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode.
  always_comb begin
    busy = (state_q != S_IDLE);
  end

  // Fetch datapath: request, address, byte index, pending line and overrun flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      y_prev    <= 10'h3FF;
      mem_req   <= 1'b0;
      mem_addr  <= ADDR_W'(FB_BASE);
      line_q    <= 10'd0;
      idx_q     <= '0;
      pend_line <= 10'd0;
      pend_ok   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      y_prev <= y;
      if (trig && (state_q != S_IDLE)) begin
        overrun   <= 1'b1;
        pend_line <= trig_tgt;
        pend_ok   <= trig_ok;
      end
      if (start) begin
        line_q   <= start_line;
        idx_q    <= '0;
        mem_addr <= line_base(start_line);
        mem_req  <= 1'b1;
      end else if (advance) begin
        idx_q    <= idx_q + IDX_W'(1);
        mem_addr <= mem_addr + ADDR_W'(1);
      end else if (finish) begin
        mem_req  <= 1'b0;
      end
    end
  end

  // Line buffer write port; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (line_q[0]) begin
        bank1[idx_q] <= mem_rdata;
      end else begin
        bank0[idx_q] <= mem_rdata;
      end
    end
  end

  // Display read selection: bank follows the parity of the displayed line.
  always_comb begin
    in_range = (x < 10'(H_RES)) && (y < 10'(V_RES));
    x_idx    = x[IDX_W-1:0];
    bank_rd  = y[0] ? bank1[x_idx] : bank0[x_idx];
  end

  // Registered pixel output, one cycle after (x,y) is presented.
  always_ff @(posedge clk) begin
    if (reset) begin
      pixelData <= 8'h00;
    end else begin
      pixelData <= in_range ? bank_rd : 8'h00;
    end
  end

endmodule

// File: tb/tb_hdmi_line_fetcher.sv
// Self-checking bench for hdmi_line_fetcher: a line-level reference model
// plus directed scenarios with literal expectations.
module tb_hdmi_line_fetcher;

  logic        clk;
  logic        reset;
  logic [9:0]  x;
  logic [9:0]  y;
  logic [7:0]  pixelData;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        busy;
  logic        overrun;

  hdmi_line_fetcher dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .pixelData(pixelData),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .busy(busy), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Memory: data byte is address low byte xor a key; ack after wcyc idle cycles.
  int       wcyc = 0;
  int       wcnt = 0;
  logic [7:0] key = 8'h00;
  always @(posedge clk) begin
    #1;
    if (mem_req) begin
      if (wcnt >= wcyc) begin
        mem_ack = 1'b1;
        wcnt    = 0;
      end else begin
        mem_ack = 1'b0;
        wcnt++;
      end
    end else begin
      mem_ack = 1'b0;
      wcnt    = 0;
    end
    mem_rdata = mem_addr[7:0] ^ key;
  end

  // Reference model: which line is wanted, which address is due, what each bank holds.
  logic [7:0]  mb [2][160];
  bit          kn [2][160];
  bit          m_req, m_busy, m_drain, m_over, m_pix_ok;
  logic [15:0] m_addr;
  logic [7:0]  m_pix;
  logic [9:0]  m_yp, m_line, m_pend, m_tgt;
  bit          m_pend_ok, m_ok, m_trig, m_ack;
  int          m_cnt;

  task automatic m_start(input logic [9:0] t);
    m_line  = t;
    m_addr  = 16'(int'(t) * 160);
    m_cnt   = 0;
    m_req   = 1;
    m_busy  = 1;
    m_drain = 0;
  endtask

  task automatic m_idle();
    m_req   = 0;
    m_busy  = 0;
    m_drain = 0;
  endtask

  task automatic m_restart();
    if (m_pend_ok) m_start(m_pend);
    else m_idle();
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_req = 0; m_busy = 0; m_drain = 0; m_over = 0;
      m_addr = 16'd0; m_pix = 8'h00; m_pix_ok = 1; m_yp = 10'h3FF;
    end else begin
      if (x < 160 && y < 120) begin
        m_pix_ok = kn[y[0]][int'(x)];
        m_pix    = mb[y[0]][int'(x)];
      end else begin
        m_pix_ok = 1;
        m_pix    = 8'h00;
      end
      m_trig = (y != m_yp);
      m_yp   = y;
      m_tgt  = (y == 10'd131) ? 10'd0 : y + 10'd1;
      m_ok   = (m_tgt < 10'd120);
      m_ack  = m_req && mem_ack;
      if (m_busy && m_trig) begin
        m_over    = 1;
        m_pend    = m_tgt;
        m_pend_ok = m_ok;
      end
      if (!m_busy) begin
        if (m_trig && m_ok) m_start(m_tgt);
      end else if (m_drain) begin
        if (m_ack) m_restart();
      end else begin
        if (m_ack) begin
          mb[m_line[0]][m_cnt] = m_addr[7:0] ^ key;
          kn[m_line[0]][m_cnt] = 1;
        end
        if (m_trig) begin
          if (m_ack) m_restart();
          else m_drain = 1;
        end else if (m_ack) begin
          if (m_cnt == 159) m_idle();
          else begin
            m_cnt++;
            m_addr = m_addr + 16'd1;
          end
        end
      end
    end
  end

  // Compare process: every output against the model on every falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("mem_req", int'(mem_req), int'(m_req));
      chk("busy", int'(busy), int'(m_busy));
      chk("overrun", int'(overrun), int'(m_over));
      chk("mem_addr", int'(mem_addr), int'(m_addr));
      if (m_pix_ok) chk("pixel", int'(pixelData), int'(m_pix));
    end
  end

  // Handshake statistics for the directed checks.
  int acks = 0, busy_cyc = 0, first_addr = -1, last_addr = -1, stab_err = 0;
  logic        p_req = 0, p_ack = 0;
  logic [15:0] p_addr = 16'd0;
  always @(negedge clk) begin
    if (busy) busy_cyc++;
    if (mem_req && mem_ack) begin
      acks++;
      if (first_addr < 0) first_addr = int'(mem_addr);
      last_addr = int'(mem_addr);
    end
    if (!reset && p_req && !p_ack && mem_req && mem_addr != p_addr) stab_err++;
    p_req  = mem_req;
    p_ack  = mem_ack;
    p_addr = mem_addr;
  end

  task automatic clear_stats();
    acks = 0; busy_cyc = 0; first_addr = -1; last_addr = -1; stab_err = 0;
  endtask

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    settle();
    while (busy && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", int'(busy), 0);
  endtask

  initial begin
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 160; i++) kn[b][i] = 0;
    reset = 1'b1; x = 10'd0; y = 10'd0; mem_ack = 1'b0; mem_rdata = 8'h00;

    // Reset state
    settle();
    chk_en = 1;
    repeat (2) settle();
    chk("rst_mem_req", int'(mem_req), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_pixel", int'(pixelData), 0);
    chk("rst_addr", int'(mem_addr), 0);

    // Zero-wait fetch: y=0 after release loads line 1, then y=1 loads line 2
    drive_edge();
    reset = 1'b0;
    wait_idle(400);
    clear_stats();
    drive_edge();
    y = 10'd1;
    wait_idle(400);
    chk("zw_acks", acks, 160);
    chk("zw_busy_cycles", busy_cyc, 160);
    chk("zw_first_addr", first_addr, 320);
    chk("zw_last_addr", last_addr, 479);
    drive_edge();
    y = 10'd2; x = 10'd5;
    settle();
    chk("zw_pixel_2_5", int'(pixelData), 8'h45);

    // Wait-state handshake
    wait_idle(400);
    key = 8'hA5; wcyc = 3;
    clear_stats();
    drive_edge();
    y = 10'd3;
    wait_idle(1500);
    chk("ws_acks", acks, 160);
    chk("ws_first_addr", first_addr, 640);
    chk("ws_addr_stable", stab_err, 0);
    chk("ws_overrun", int'(overrun), 0);

    // Frame wrap
    wcyc = 0;
    drive_edge();
    y = 10'd118;
    wait_idle(400);
    clear_stats();
    drive_edge();
    y = 10'd119;
    settle();
    chk("wrap_no_fetch_119", int'(busy), 0);
    for (int v = 120; v <= 130; v++) begin
      drive_edge();
      y = 10'(v);
    end
    settle();
    chk("wrap_no_fetch_acks", acks, 0);
    clear_stats();
    drive_edge();
    y = 10'd131;
    wait_idle(400);
    chk("wrap_acks", acks, 160);
    chk("wrap_first_addr", first_addr, 0);
    chk("wrap_last_addr", last_addr, 159);
    drive_edge();
    y = 10'd0; x = 10'd0;
    settle();
    chk("wrap_pixel_0_0", int'(pixelData), 8'hA5);
    drive_edge();
    x = 10'd160;
    settle();
    chk("wrap_pixel_x160", int'(pixelData), 0);
    drive_edge();
    y = 10'd120; x = 10'd3;
    settle();
    chk("wrap_pixel_y120", int'(pixelData), 0);
    wait_idle(400);

    // Overrun: slow memory, y moves on mid-line
    wcyc = 29;
    drive_edge();
    y = 10'd10;
    repeat (600) @(posedge clk);
    #1;
    y = 10'd11;
    settle();
    chk("ovr_set", int'(overrun), 1);
    begin
      int n;
      n = 0;
      while (mem_addr != 16'd1920 && n < 200) begin
        @(negedge clk);
        n++;
      end
      chk("ovr_restart_base", int'(mem_addr), 1920);
    end
    repeat (200) @(negedge clk);
    chk("ovr_sticky", int'(overrun), 1);

    // Reset mid-fetch
    wcyc = 0;
    wait_idle(400);
    clear_stats();
    drive_edge();
    y = 10'd20;
    begin
      int n;
      n = 0;
      while (acks < 50 && n < 300) begin
        @(negedge clk);
        n++;
      end
      chk("mid_reach_50", acks, 50);
    end
    drive_edge();
    reset = 1'b1;
    settle();
    chk("mid_rst_req", int'(mem_req), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_overrun", int'(overrun), 0);
    chk("mid_rst_pixel", int'(pixelData), 0);
    drive_edge();
    reset = 1'b0;
    settle();
    chk("mid_restart_busy", int'(busy), 1);
    chk("mid_restart_req", int'(mem_req), 1);
    chk("mid_restart_addr", int'(mem_addr), 3360);
    wait_idle(400);

    // Latency: random x on a loaded bank, then y hopping in and out of range
    drive_edge();
    y = 10'd21;
    for (int i = 0; i < 100; i++) begin
      drive_edge();
      x = 10'($urandom_range(0, 199));
    end
    for (int i = 0; i < 200; i++) begin
      drive_edge();
      x = 10'($urandom_range(0, 199));
      y = ($urandom_range(0, 1) != 0) ? 10'd21 : 10'd125;
    end
    wait_idle(2000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
